acc_cpu_core: RTL and testbench

//   Accumulator CPU sequencer: the initiator side of the 256x16 instruction/data RAM port.

---
 rtl/acc_cpu_core.sv | 179 +++++++++++++++++
 tb/tb_acc_cpu_core.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_cpu_core.sv
// acc_cpu_core: accumulator CPU sequencer driving a 256x16 synchronous RAM port.
// Four-cycle fetch/wait/decode/execute loop with an I/O handshake state for Input/Output.
// Optional single-step control is compiled in with the ACC_CPU_STEP_EN macro.
module acc_cpu_core #(
  parameter int unsigned IO_TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,
  output logic [7:0]  mem_addr,
  output logic [15:0] mem_din,
  output logic        mem_we,
  input  logic [15:0] mem_dout,
  output logic [7:0]  io_addr,
  output logic        io_req,
  output logic        io_we,
  output logic [7:0]  io_wdata,
  input  logic [7:0]  io_rdata,
  input  logic        io_ack,
  output logic [7:0]  acc,
  output logic [7:0]  pc,
  output logic        flag_z,
  output logic        flag_c,
  output logic        illegal,
  output logic        io_err
`ifdef ACC_CPU_STEP_EN
  ,
  input  logic        step
`endif
);

  localparam int unsigned DW = 8;
  localparam int unsigned IW = 16;
  localparam int unsigned OW = 4;
  localparam logic [DW-1:0] TO_LAST = DW'(IO_TIMEOUT - 1);

  localparam logic [OW-1:0] OP_LOAD = 4'b0000;
  localparam logic [OW-1:0] OP_AND  = 4'b0001;
  localparam logic [OW-1:0] OP_ADD  = 4'b0100;
  localparam logic [OW-1:0] OP_SUB  = 4'b0110;
  localparam logic [OW-1:0] OP_JMP  = 4'b1000;
  localparam logic [OW-1:0] OP_JCC  = 4'b1001;
  localparam logic [OW-1:0] OP_IN   = 4'b1010;
  localparam logic [OW-1:0] OP_OUT  = 4'b1110;

  typedef enum logic [2:0] {S_FETCH, S_WAIT, S_DEC, S_EXEC, S_IO} state_t;

  state_t        state;
  logic [IW-1:0] ir;
  logic [DW-1:0] io_cnt;

  logic [OW-1:0] op;
  logic [DW-1:0] kk;
  logic [DW-1:0] and_res;
  logic [DW:0]   add_sum;
  logic [DW:0]   sub_dif;
  logic          cond_flag;
  logic          jump_taken;
  logic          fetch_go;
  logic          unused_ir_bits;

  // The ISA has no store, so the write side of the RAM port is tied off
  assign mem_din = '0;
  assign mem_we  = 1'b0;

  // ir[9:8] have no meaning for any opcode
  assign unused_ir_bits = ^ir[9:8];

`ifdef ACC_CPU_STEP_EN
  assign fetch_go = step;
`else
  assign fetch_go = 1'b1;
`endif

  // Decode fields, ALU results and conditional-jump evaluation for the held instruction
  always_comb begin
    op         = ir[15:12];
    kk         = ir[7:0];
    and_res    = acc & kk;
    add_sum    = {1'b0, acc} + {1'b0, kk};
    sub_dif    = {1'b0, acc} - {1'b0, kk};
    cond_flag  = ir[11] ? flag_c : flag_z;
    jump_taken = ir[10] ? ~cond_flag : cond_flag;
  end

  // Sequencer FSM with all architectural state and port outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_FETCH;
      ir       <= '0;
      io_cnt   <= '0;
      pc       <= '0;
      acc      <= '0;
      flag_z   <= 1'b0;
      flag_c   <= 1'b0;
      mem_addr <= '0;
      io_req   <= 1'b0;
      io_we    <= 1'b0;
      io_addr  <= '0;
      io_wdata <= '0;
      illegal  <= 1'b0;
      io_err   <= 1'b0;
    end else begin
      illegal <= 1'b0;
      io_err  <= 1'b0;
      case (state)
        S_FETCH: begin
          if (fetch_go) begin
            mem_addr <= pc;
            state    <= S_WAIT;
          end
        end
        S_WAIT: state <= S_DEC;
        S_DEC: begin
          ir    <= mem_dout;
          state <= S_EXEC;
        end
        S_EXEC: begin
          state <= S_FETCH;
          pc    <= pc + 8'd1;
          case (op)
            OP_LOAD: begin
              acc    <= kk;
              flag_z <= (kk == '0);
            end
            OP_AND: begin
              acc    <= and_res;
              flag_z <= (and_res == '0);
            end
            OP_ADD: begin
              acc    <= add_sum[DW-1:0];
              flag_c <= add_sum[DW];
              flag_z <= (add_sum[DW-1:0] == '0);
            end
            OP_SUB: begin
              acc    <= sub_dif[DW-1:0];
              flag_c <= sub_dif[DW];
              flag_z <= (sub_dif[DW-1:0] == '0);
            end
            OP_JMP: pc <= kk;
            OP_JCC: begin
              if (jump_taken) pc <= kk;
            end
            OP_IN, OP_OUT: begin
              // pc advances only when the transfer completes or times out
              pc       <= pc;
              io_req   <= 1'b1;
              io_addr  <= kk;
              io_we    <= (op == OP_OUT);
              io_wdata <= acc;
              io_cnt   <= '0;
              state    <= S_IO;
            end
            default: illegal <= 1'b1;
          endcase
        end
        S_IO: begin
          if (io_ack) begin
            io_req <= 1'b0;
            if (!io_we) begin
              acc    <= io_rdata;
              flag_z <= (io_rdata == '0);
            end
            pc    <= pc + 8'd1;
            state <= S_FETCH;
          end else if (io_cnt == TO_LAST) begin
            io_req <= 1'b0;
            io_err <= 1'b1;
            pc     <= pc + 8'd1;
            state  <= S_FETCH;
          end else begin
            io_cnt <= io_cnt + 8'd1;
          end
        end
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_cpu_core.sv
// Self-checking bench for acc_cpu_core: program-level scenarios with an
// architectural-state scoreboard ({acc, pc, flag_z, flag_c}) checked at each retire.
module tb_acc_cpu_core;

  logic        clock;
  logic        reset;
  logic [7:0]  mem_addr;
  logic [15:0] mem_din;
  logic        mem_we;
  logic [15:0] mem_dout;
  logic [7:0]  io_addr;
  logic        io_req;
  logic        io_we;
  logic [7:0]  io_wdata;
  logic [7:0]  io_rdata;
  logic        io_ack;
  logic [7:0]  acc;
  logic [7:0]  pc;
  logic        flag_z;
  logic        flag_c;
  logic        illegal;
  logic        io_err;
`ifdef ACC_CPU_STEP_EN
  logic        step;
`endif

  logic [15:0] ram [256];
  logic [17:0] arch;
  logic [17:0] exp_q [$];
  int          n_checks;
  int          n_pass;

  assign arch = {acc, pc, flag_z, flag_c};

  acc_cpu_core #(.IO_TIMEOUT(4)) dut (
    .clock    (clock),
    .reset    (reset),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_we   (mem_we),
    .mem_dout (mem_dout),
    .io_addr  (io_addr),
    .io_req   (io_req),
    .io_we    (io_we),
    .io_wdata (io_wdata),
    .io_rdata (io_rdata),
    .io_ack   (io_ack),
    .acc      (acc),
    .pc       (pc),
    .flag_z   (flag_z),
    .flag_c   (flag_c),
    .illegal  (illegal),
    .io_err   (io_err)
`ifdef ACC_CPU_STEP_EN
    ,
    .step     (step)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous-read RAM model
  always @(posedge clock) mem_dout <= ram[mem_addr];

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic run_cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic clear_ram();
    for (int i = 0; i < 256; i++) ram[i] = 16'h0000;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset  = 1'b1;
    io_ack = 1'b0;
    run_cycles(2);
    reset = 1'b0;
  endtask

  task automatic ack_after(input int delay, input logic [7:0] data);
    run_cycles(delay);
    io_rdata = data;
    io_ack   = 1'b1;
    run_cycles(1);
    io_ack   = 1'b0;
    io_rdata = 8'h00;
  endtask

  task automatic test_reset();
    logic [44:0] got;
    reset  = 1'b1;
    io_ack = 1'b0;
    run_cycles(3);
    got = {arch, mem_addr, io_req, io_we, io_addr, io_wdata, illegal, io_err, mem_we};
    n_checks++;
    if (got !== 45'h0) $display("FAIL reset_state: got %h expected %h", got, 45'h0);
    else n_pass++;
    n_checks++;
    if (mem_din !== 16'h0000) $display("FAIL mem_din: got %h expected 0000", mem_din);
    else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_program_a();
    logic [17:0] exp;
    clear_ram();
    ram[0] = 16'hA006; ram[1] = 16'h400A; ram[2] = 16'h9404;
    ram[3] = 16'h00FF; ram[4] = 16'hE007; ram[5] = 16'h8000;
    do_reset();
    exp_q.push_back({8'h05, 8'h01, 1'b0, 1'b0});
    run_cycles(4);
    n_checks++;
    if ({io_req, io_we, io_addr} !== {1'b1, 1'b0, 8'h06})
      $display("FAIL progA_input_req: got %b/%b/%h expected 1/0/06", io_req, io_we, io_addr);
    else n_pass++;
    ack_after(2, 8'h05);
    exp = exp_q.pop_front();
    n_checks++;
    if (arch !== exp) $display("FAIL progA_input: got %h expected %h", arch, exp);
    else n_pass++;
    exp_q.push_back({8'h0F, 8'h02, 1'b0, 1'b0});
    exp_q.push_back({8'h0F, 8'h04, 1'b0, 1'b0});
    for (int i = 0; i < 2; i++) begin
      run_cycles(4);
      exp = exp_q.pop_front();
      n_checks++;
      if (arch !== exp) $display("FAIL progA_step%0d: got %h expected %h", i, arch, exp);
      else n_pass++;
    end
    exp_q.push_back({8'h0F, 8'h05, 1'b0, 1'b0});
    run_cycles(4);
    n_checks++;
    if ({io_req, io_we, io_addr, io_wdata} !== {1'b1, 1'b1, 8'h07, 8'h0F})
      $display("FAIL progA_output_req: got %b/%b/%h/%h expected 1/1/07/0F", io_req, io_we, io_addr, io_wdata);
    else n_pass++;
    ack_after(0, 8'hEE);
    exp = exp_q.pop_front();
    n_checks++;
    if (arch !== exp) $display("FAIL progA_output: got %h expected %h", arch, exp);
    else n_pass++;
    exp_q.push_back({8'h0F, 8'h00, 1'b0, 1'b0});
    run_cycles(4);
    exp = exp_q.pop_front();
    n_checks++;
    if (arch !== exp) $display("FAIL progA_jump_home: got %h expected %h", arch, exp);
    else n_pass++;
  endtask

  task automatic test_add_carry_jumps();
    logic [17:0] exp;
    clear_ram();
    ram[0] = 16'h00FA; ram[1] = 16'h4006; ram[2] = 16'h9010; ram[8'h10] = 16'h9C20;
    do_reset();
    exp_q.push_back({8'hFA, 8'h01, 1'b0, 1'b0});
    exp_q.push_back({8'h00, 8'h02, 1'b1, 1'b1});
    exp_q.push_back({8'h00, 8'h10, 1'b1, 1'b1});
    exp_q.push_back({8'h00, 8'h11, 1'b1, 1'b1});
    for (int i = 0; i < 4; i++) begin
      run_cycles(4);
      exp = exp_q.pop_front();
      n_checks++;
      if (arch !== exp) $display("FAIL add_jump_step%0d: got %h expected %h", i, arch, exp);
      else n_pass++;
    end
  endtask

  task automatic test_sub_and();
    logic [17:0] exp;
    clear_ram();
    ram[0] = 16'h0003; ram[1] = 16'h6005; ram[2] = 16'h60FE;
    ram[3] = 16'h6001; ram[4] = 16'h1000;
    do_reset();
    exp_q.push_back({8'h03, 8'h01, 1'b0, 1'b0});
    exp_q.push_back({8'hFE, 8'h02, 1'b0, 1'b1});
    exp_q.push_back({8'h00, 8'h03, 1'b1, 1'b0});
    exp_q.push_back({8'hFF, 8'h04, 1'b0, 1'b1});
    exp_q.push_back({8'h00, 8'h05, 1'b1, 1'b1});
    // a stray ack during a non-I/O instruction must have no effect
    io_rdata = 8'hAA;
    io_ack   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      run_cycles(4);
      io_ack   = 1'b0;
      io_rdata = 8'h00;
      exp = exp_q.pop_front();
      n_checks++;
      if (arch !== exp) $display("FAIL sub_and_step%0d: got %h expected %h", i, arch, exp);
      else n_pass++;
    end
  endtask

  task automatic test_io_timeout();
    logic [17:0] exp;
    int req_cnt;
    int err_cnt;
    clear_ram();
    ram[0] = 16'h0033; ram[1] = 16'hA009; ram[2] = 16'h8002;
    do_reset();
    exp_q.push_back({8'h33, 8'h01, 1'b0, 1'b0});
    exp_q.push_back({8'h33, 8'h02, 1'b0, 1'b0});
    run_cycles(4);
    exp = exp_q.pop_front();
    n_checks++;
    if (arch !== exp) $display("FAIL timeout_load: got %h expected %h", arch, exp);
    else n_pass++;
    run_cycles(4);
    n_checks++;
    if ({io_req, io_we, io_addr} !== {1'b1, 1'b0, 8'h09})
      $display("FAIL timeout_req: got %b/%b/%h expected 1/0/09", io_req, io_we, io_addr);
    else n_pass++;
    req_cnt = 0;
    err_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (io_req) req_cnt++;
      if (io_err) err_cnt++;
      run_cycles(1);
    end
    n_checks++;
    if (req_cnt !== 4) $display("FAIL timeout_req_cycles: got %0d expected 4", req_cnt);
    else n_pass++;
    n_checks++;
    if (err_cnt !== 1) $display("FAIL timeout_err_pulses: got %0d expected 1", err_cnt);
    else n_pass++;
    exp = exp_q.pop_front();
    n_checks++;
    if (arch !== exp) $display("FAIL timeout_state: got %h expected %h", arch, exp);
    else n_pass++;
  endtask

  task automatic test_reset_in_io();
    logic [17:0] exp;
    clear_ram();
    ram[0] = 16'h0055; ram[1] = 16'hA001;
    do_reset();
    exp_q.push_back({8'h55, 8'h01, 1'b0, 1'b0});
    run_cycles(4);
    exp = exp_q.pop_front();
    n_checks++;
    if (arch !== exp) $display("FAIL rst_io_load: got %h expected %h", arch, exp);
    else n_pass++;
    run_cycles(4);
    n_checks++;
    if (io_req !== 1'b1) $display("FAIL rst_io_req_up: got %b expected 1", io_req);
    else n_pass++;
    reset = 1'b1;
    run_cycles(1);
    n_checks++;
    if ({io_req, mem_addr, arch} !== {1'b0, 8'h00, 18'h0})
      $display("FAIL rst_io_drop: got %b/%h/%h expected 0/00/00000", io_req, mem_addr, arch);
    else n_pass++;
    ram[0] = 16'h80FF; ram[8'hFF] = 16'h80FF;
    reset = 1'b0;
    run_cycles(1);
    n_checks++;
    if (mem_addr !== 8'h00) $display("FAIL rst_io_refetch: got %h expected 00", mem_addr);
    else n_pass++;
    exp_q.push_back({8'h00, 8'hFF, 1'b0, 1'b0});
    exp_q.push_back({8'h00, 8'hFF, 1'b0, 1'b0});
    run_cycles(3);
    for (int i = 0; i < 2; i++) begin
      exp = exp_q.pop_front();
      n_checks++;
      if (arch !== exp) $display("FAIL jump_self_%0d: got %h expected %h", i, arch, exp);
      else n_pass++;
      run_cycles(4);
    end
  endtask

  task automatic test_illegal_wrap();
    logic [17:0] exp;
    clear_ram();
    ram[0] = 16'h0001; ram[1] = 16'h40FF; ram[2] = 16'h2ABC; ram[3] = 16'h80FE;
    ram[8'hFE] = 16'hF000; ram[8'hFF] = 16'h0042;
    do_reset();
    exp_q.push_back({8'h01, 8'h01, 1'b0, 1'b0});
    exp_q.push_back({8'h00, 8'h02, 1'b1, 1'b1});
    exp_q.push_back({8'h00, 8'h03, 1'b1, 1'b1});
    for (int i = 0; i < 3; i++) begin
      run_cycles(4);
      exp = exp_q.pop_front();
      n_checks++;
      if (arch !== exp) $display("FAIL illegal_step%0d: got %h expected %h", i, arch, exp);
      else n_pass++;
    end
    n_checks++;
    if (illegal !== 1'b1) $display("FAIL illegal_pulse: got %b expected 1", illegal);
    else n_pass++;
    run_cycles(1);
    n_checks++;
    if (illegal !== 1'b0) $display("FAIL illegal_pulse_end: got %b expected 0", illegal);
    else n_pass++;
    exp_q.push_back({8'h00, 8'hFE, 1'b1, 1'b1});
    exp_q.push_back({8'h00, 8'hFF, 1'b1, 1'b1});
    exp_q.push_back({8'h42, 8'h00, 1'b0, 1'b1});
    run_cycles(3);
    for (int i = 0; i < 3; i++) begin
      exp = exp_q.pop_front();
      n_checks++;
      if (arch !== exp) $display("FAIL wrap_step%0d: got %h expected %h", i, arch, exp);
      else n_pass++;
      if (i == 1) begin
        n_checks++;
        if (illegal !== 1'b1) $display("FAIL illegal_f_pulse: got %b expected 1", illegal);
        else n_pass++;
      end
      if (i < 2) run_cycles(4);
    end
  endtask

`ifdef ACC_CPU_STEP_EN
  task automatic test_step();
    logic [17:0] exp;
    clear_ram();
    for (int i = 0; i < 8; i++) ram[i] = 16'h4001;
    step = 1'b0;
    do_reset();
    exp_q.push_back({8'h00, 8'h00, 1'b1, 1'b0});
    exp_q.push_back({8'h03, 8'h03, 1'b0, 1'b0});
    run_cycles(10);
    exp = exp_q.pop_front();
    exp[1] = 1'b0;
    n_checks++;
    if (arch !== exp) $display("FAIL step_hold: got %h expected %h", arch, exp);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      step = 1'b1;
      run_cycles(1);
      step = 1'b0;
      run_cycles(7);
    end
    exp = exp_q.pop_front();
    n_checks++;
    if (arch !== exp) $display("FAIL step_three: got %h expected %h", arch, exp);
    else n_pass++;
    step = 1'b1;
  endtask
`endif

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b1;
    io_ack   = 1'b0;
    io_rdata = 8'h00;
`ifdef ACC_CPU_STEP_EN
    step     = 1'b1;
`endif
    clear_ram();
    test_reset();
    test_program_a();
    test_add_carry_jumps();
    test_sub_and();
    test_io_timeout();
    test_reset_in_io();
    test_illegal_wrap();
`ifdef ACC_CPU_STEP_EN
    test_step();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
